vga_pattern_gen: RTL and testbench
==================================

# vga_pattern_gen

Parametrised VGA timing and test-pattern generator. It drives the board's 3-bit VGA connector directly from the pixel clock. Sync timing is fully parametrised and sync polarity is selectable. It provides a registered, aligned data-enable, a frame-start strobe, and four run-time-selectable patterns. It is the timing backbone that later framebuffer and sprite blocks will consume via `HCOUNT`, `VCOUNT`, `DE` and `FRAME_START`.

## Interface
- `H_ACTIVE`, 640, visible pixels per line
- `H_FP`, 16, horizontal front porch (cycles)
- `H_SYNC`, 96, horizontal sync width (cycles)
- `H_BP`, 48, horizontal back porch (cycles)
- `V_ACTIVE`, 480, visible lines per frame
- `V_FP`, 10, vertical front porch (lines)
- `V_SYNC`, 2, vertical sync width (lines)
- `V_BP`, 33, vertical back porch (lines)
- `HS_POL`, 0, HSYNC active level (0 = active-low)
- `VS_POL`, 0, VSYNC active level
- `CW`, 11, counter width; requires H_TOTAL ≤ 2^CW and V_TOTAL ≤ 2^CW
- `SQ_LOG2`, 5, checker square size = 2^SQ_LOG2 pixels
- `CLK_24M  in  1`  pixel clock
- `RST_N  in  1`  asynchronous active-low reset
- `MODE  in  2`  pattern select: 00 binary counter, 01 colour bars, 10 checker, 11 solid white
- `VGA_RGB  out  3`  pixel colour {B,G,R}; zero outside active area
- `HSYNC  out  1`  horizontal sync, polarity per HS_POL
- `VSYNC  out  1`  vertical sync, polarity per VS_POL
- `DE  out  1`  high for active pixels, aligned with VGA_RGB
- `FRAME_START  out  1`  one-cycle pulse coincident with pixel (0,0) on the outputs
- `HCOUNT  out  CW`  current horizontal counter (pre-register)
- `VCOUNT  out  CW`  current vertical counter (pre-register)

## Operation
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800); V_TOTAL likewise (525).
- hcount counts 0..H_TOTAL-1 and then wraps to 0.
- vcount increments in the same cycle that hcount wraps, with no one-line lag. It wraps from V_TOTAL-1 to 0.
- Horizontal sync is asserted for hcount in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1] (656..751).
- Vertical sync is asserted for vcount in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1] (490..491), across whole lines.
- The active region is hcount < H_ACTIVE and vcount < V_ACTIVE, inclusive of pixel 639 and line 479.
- MODE is sampled into mode_q only when hcount = 0 and vcount = 0. A change mid-frame takes effect at the next frame.
- Patterns, with x = hcount and y = vcount:
  - Binary counter: all three RGB bits = y[(x >> 6) mod CW].
  - Colour bars: RGB = bar index, where bar = x·8 / H_ACTIVE, giving 0..7.
  - Checker: RGB = 3'b111 if x[SQ_LOG2] ^ y[SQ_LOG2], else 0.
  - Solid white: RGB = 3'b111.
- Outside the active region, VGA_RGB = 0 and DE = 0 regardless of mode.
- Reset (asynchronous, any time, including mid-frame):
  - hcount, vcount and mode_q go to 0.
  - VGA_RGB = 0, DE = 0, FRAME_START = 0.
  - HSYNC = ~HS_POL and VSYNC = ~VS_POL (inactive).
  - The first cycle after release treats counters as (0,0).

## Timing
- VGA_RGB, DE, HSYNC, VSYNC and FRAME_START are registered. They have exactly 1 cycle latency relative to HCOUNT/VCOUNT and are mutually aligned.
- FRAME_START is high for exactly one cycle per frame, the cycle where DE shows pixel (0,0). The period is H_TOTAL·V_TOTAL = 420000 cycles.
- Per line, DE is high for 640 consecutive cycles and HSYNC is active for 96. HSYNC activates 656 cycles after DE rises.
- Per frame, VSYNC is active for V_SYNC·H_TOTAL = 1600 consecutive cycles, with edges aligned to hcount = 0.
- At the boundary hcount = H_TOTAL-1 and vcount = V_TOTAL-1, both counters wrap to 0 on the same edge.

## Configuration
- `VGA_SCROLL_EN` defined:
  - An 8-bit frame counter is reset to 0 and increments at each FRAME_START.
  - The bars and checker patterns use x' = (hcount + frame_cnt) mod 2^CW, but are still blanked by the unmodified hcount.
  - The binary pattern uses y' = (vcount + frame_cnt) mod 2^CW.
  - Images scroll 1 pixel per frame.
- Undefined: the frame counter is absent and patterns are static. The other outputs are cycle-identical to the enabled build in frame 0.

## Test plan
- Reset check: hold RST_N = 0 → VGA_RGB = 0, DE = 0, FRAME_START = 0, HSYNC = 1, VSYNC = 1 (default polarities). Release RST_N → HCOUNT = 0 on the first cycle.
- Horizontal timing: run 3 lines → DE high 640 cycles per 800, HSYNC low 96 cycles, HSYNC falls 656 cycles after DE rises, no DE during sync.
- Vertical and frame timing: run 2 frames → FRAME_START period 420000 cycles, VSYNC low 1600 cycles starting at line 490, DE low on lines 480..524.
- Binary pattern, MODE = 00, line 5 → pixels 0..63 RGB = 111, pixels 64..127 RGB = 000, pixels 128..191 RGB = 111.
- Mode change: switch MODE 00 → 01 at line 200 → frame unchanged until next FRAME_START, after which pixel 80 shows RGB = 001 and pixel 639 shows RGB = 111.
- Mid-frame reset: pulse RST_N low at line 300 with VGA_SCROLL_EN defined → outputs return to reset values asynchronously, frame counter = 0, next FRAME_START occurs 1 cycle after release.

Source files
------------

// File: rtl/vga_pattern_gen.sv
// vga_pattern_gen: parametrised VGA timing and test-pattern generator; define VGA_SCROLL_EN to scroll patterns one pixel per frame.
module vga_pattern_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP = 16,
  parameter int H_SYNC = 96,
  parameter int H_BP = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP = 10,
  parameter int V_SYNC = 2,
  parameter int V_BP = 33,
  parameter bit HS_POL = 1'b0,
  parameter bit VS_POL = 1'b0,
  parameter int CW = 11,
  parameter int SQ_LOG2 = 5
) (
  input  logic          CLK_24M,
  input  logic          RST_N,
  input  logic [1:0]    MODE,
  output logic [2:0]    VGA_RGB,
  output logic          HSYNC,
  output logic          VSYNC,
  output logic          DE,
  output logic          FRAME_START,
  output logic [CW-1:0] HCOUNT,
  output logic [CW-1:0] VCOUNT
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  logic [CW-1:0] hcount, vcount, xs, ys;
  logic [1:0] mode_q, mode_eff;
  logic [31:0] bidx;
  logic [2:0] bar, rgb_d;
  logic h_end, v_end, origin, active, hs_act, vs_act, ybit;
  assign HCOUNT = hcount;
  assign VCOUNT = vcount;
  assign h_end = hcount == CW'(H_TOTAL - 1);
  assign v_end = vcount == CW'(V_TOTAL - 1);
  assign origin = hcount == '0 && vcount == '0;
  assign active = hcount < CW'(H_ACTIVE) && vcount < CW'(V_ACTIVE);
  assign hs_act = hcount >= CW'(H_ACTIVE + H_FP) && hcount < CW'(H_ACTIVE + H_FP + H_SYNC);
  assign vs_act = vcount >= CW'(V_ACTIVE + V_FP) && vcount < CW'(V_ACTIVE + V_FP + V_SYNC);
  // The frame's mode is taken at (0,0) so pixel (0,0) already shows it
  assign mode_eff = origin ? MODE : mode_q;
`ifdef VGA_SCROLL_EN
  logic [7:0] frame_cnt;
  always_ff @(posedge CLK_24M or negedge RST_N)
    if (!RST_N) frame_cnt <= '0;
    else if (h_end && v_end) frame_cnt <= frame_cnt + 1'b1;
  assign xs = hcount + CW'(frame_cnt);
  assign ys = vcount + CW'(frame_cnt);
`else
  assign xs = hcount;
  assign ys = vcount;
`endif
  always_comb begin
    bidx = 32'(hcount >> 6) % 32'(CW);
    ybit = 1'(ys >> bidx);
    bar = 3'((32'(xs) * 32'd8) / 32'(H_ACTIVE));
    rgb_d = mode_eff == 2'b00 ? {3{ybit}} :
            mode_eff == 2'b01 ? bar :
            mode_eff == 2'b10 ? {3{xs[SQ_LOG2] ^ vcount[SQ_LOG2]}} : 3'b111;
  end
  always_ff @(posedge CLK_24M or negedge RST_N)
    if (!RST_N) begin
      hcount <= '0;
      vcount <= '0;
      mode_q <= '0;
    end else begin
      hcount <= h_end ? '0 : hcount + 1'b1;
      if (h_end) vcount <= v_end ? '0 : vcount + 1'b1;
      mode_q <= mode_eff;
    end
  always_ff @(posedge CLK_24M or negedge RST_N)
    if (!RST_N) begin
      VGA_RGB <= '0;
      DE <= 1'b0;
      HSYNC <= ~HS_POL;
      VSYNC <= ~VS_POL;
      FRAME_START <= 1'b0;
    end else begin
      VGA_RGB <= active ? rgb_d : '0;
      DE <= active;
      HSYNC <= hs_act ? HS_POL : ~HS_POL;
      VSYNC <= vs_act ? VS_POL : ~VS_POL;
      FRAME_START <= origin;
    end
endmodule

// File: tb/tb_vga_pattern_gen.sv
// tb_vga_pattern_gen: random mode/reset stimulus with a queue scoreboard against a frame-level reference model.
module tb_vga_pattern_gen;
  localparam int HA = 160, HF = 8, HSW = 12, HB = 10;
  localparam int VA = 20, VF = 2, VSW = 2, VB = 3;
  localparam bit HP = 1'b0, VP = 1'b1;
  localparam int CW = 8, SQ = 2;
  localparam int HT = HA + HF + HSW + HB;
  localparam int VT = VA + VF + VSW + VB;
  localparam int FR = HT * VT;
  typedef struct {
    logic [2:0] rgb;
    logic de, hs, vs, fs;
    logic [CW-1:0] hc, vc;
  } exp_t;
  logic CLK_24M, RST_N;
  logic [1:0] MODE;
  logic [2:0] VGA_RGB;
  logic HSYNC, VSYNC, DE, FRAME_START;
  logic [CW-1:0] HCOUNT, VCOUNT;
  exp_t q[$];
  exp_t m;
  int total = 0, bad = 0, t = 0, frame_k = 0;
  logic [1:0] fmode = 2'b00;
  bit started = 0;

  vga_pattern_gen #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSW), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSW), .V_BP(VB),
    .HS_POL(HP), .VS_POL(VP), .CW(CW), .SQ_LOG2(SQ)
  ) dut (
    .CLK_24M(CLK_24M), .RST_N(RST_N), .MODE(MODE), .VGA_RGB(VGA_RGB),
    .HSYNC(HSYNC), .VSYNC(VSYNC), .DE(DE), .FRAME_START(FRAME_START),
    .HCOUNT(HCOUNT), .VCOUNT(VCOUNT)
  );

  initial CLK_24M = 1'b0;
  always #5 CLK_24M = ~CLK_24M;

  task automatic check_async();
    total++;
    if (VGA_RGB !== 3'b0 || DE !== 1'b0 || FRAME_START !== 1'b0 || HSYNC !== ~HP || VSYNC !== ~VP || HCOUNT !== '0 || VCOUNT !== '0) begin
      bad++;
      $display("FAIL async_reset got rgb=%b de=%b hs=%b vs=%b fs=%b h=%0d v=%0d want rgb=000 de=0 hs=%b vs=%b fs=0 h=0 v=0",
               VGA_RGB, DE, HSYNC, VSYNC, FRAME_START, HCOUNT, VCOUNT, ~HP, ~VP);
    end
  endtask

  task automatic step(input logic rn);
    exp_t e;
    int h, v, p;
    @(negedge CLK_24M);
    if (!rn && RST_N) begin
      #2 RST_N = 1'b0;
      #1 check_async();
    end else RST_N = rn;
    if (!rn) begin
      e.rgb = 3'b0; e.de = 1'b0; e.hs = ~HP; e.vs = ~VP; e.fs = 1'b0; e.hc = '0; e.vc = '0;
      t = 0;
    end else begin
      h = t % HT;
      v = (t / HT) % VT;
      if (h == 0 && v == 0) begin
        MODE = 2'(frame_k);
        frame_k++;
        fmode = MODE;
      end else if ($urandom_range(0, 199) == 0) MODE = 2'($urandom_range(0, 3));
      case (fmode)
        2'b00: p = ((v >> ((h / 64) % CW)) & 1) != 0 ? 7 : 0;
        2'b01: p = (h * 8) / HA;
        2'b10: p = (((h >> SQ) ^ (v >> SQ)) & 1) != 0 ? 7 : 0;
        default: p = 7;
      endcase
      e.de = h < HA && v < VA;
      e.rgb = e.de ? 3'(p) : 3'b0;
      e.hs = (h >= HA + HF && h < HA + HF + HSW) ? HP : ~HP;
      e.vs = (v >= VA + VF && v < VA + VF + VSW) ? VP : ~VP;
      e.fs = h == 0 && v == 0;
      e.hc = CW'((t + 1) % HT);
      e.vc = CW'(((t + 1) / HT) % VT);
      t++;
    end
    q.push_back(e);
    started = 1;
  endtask

  always @(posedge CLK_24M) begin
    #1;
    if (q.size() != 0) begin
      m = q.pop_front();
      total++;
      if (VGA_RGB !== m.rgb || DE !== m.de || HSYNC !== m.hs || VSYNC !== m.vs || FRAME_START !== m.fs || HCOUNT !== m.hc || VCOUNT !== m.vc) begin
        bad++;
        $display("FAIL pixel @%0t got rgb=%b de=%b hs=%b vs=%b fs=%b h=%0d v=%0d want rgb=%b de=%b hs=%b vs=%b fs=%b h=%0d v=%0d",
                 $time, VGA_RGB, DE, HSYNC, VSYNC, FRAME_START, HCOUNT, VCOUNT, m.rgb, m.de, m.hs, m.vs, m.fs, m.hc, m.vc);
      end
    end else if (started) begin
      total++;
      bad++;
      $display("FAIL underflow @%0t got queue=0 want queue>0", $time);
    end
  end

  initial begin
    RST_N = 1'b0;
    MODE = 2'b00;
    frame_k = int'($urandom_range(0, 3));
    repeat (3) step(1'b0);
    repeat (4 * FR + int'($urandom_range(100, FR - 1))) step(1'b1);
    repeat (2) step(1'b0);
    repeat (3 * FR + 50) step(1'b1);
    started = 0;
    @(posedge CLK_24M);
    #3;
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL drain got queue=%0d want queue=0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
